// File: rtl/gcd_stream.sv
// Binary (Stein) GCD engine with result-hold handshake, coprime flag and a
// saturating busy-cycle counter. One FSM state per clock.
module gcd_stream #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ack_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             coprime_o,
    output logic [CNT_W-1:0] cycles_o
);
    localparam int K_W = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE, CHECK, FACTOR2, NORM_A, NORM_B, ORDER, SUB, DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a, a_nxt, b, b_nxt, result, result_nxt, diff;
    logic [K_W-1:0]   k, k_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc, cycles, cycles_nxt;
    logic             coprime, coprime_nxt, busy;

    assign busy    = (state != IDLE) && (state != DONE);
    assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
    assign diff    = b - a;

    always_comb begin
        state_nxt   = state;
        a_nxt       = a;
        b_nxt       = b;
        k_nxt       = k;
        result_nxt  = result;
        coprime_nxt = coprime;
        cycles_nxt  = cycles;
        cnt_nxt     = busy ? cnt_inc : cnt;
        case (state)
            IDLE: if (start_i) begin
                a_nxt     = a_i;
                b_nxt     = b_i;
                k_nxt     = '0;
                cnt_nxt   = '0;
                state_nxt = CHECK;
            end
            CHECK: begin
                if (a == '0) begin
                    result_nxt = b;
                    state_nxt  = DONE;
                end else if (b == '0) begin
                    result_nxt = a;
                    state_nxt  = DONE;
                end else begin
                    state_nxt = FACTOR2;
                end
            end
            FACTOR2: begin
                if (!(a[0] | b[0])) begin
                    a_nxt = a >> 1;
                    b_nxt = b >> 1;
                    k_nxt = k + K_W'(1);
                end else begin
                    state_nxt = NORM_A;
                end
            end
            NORM_A: begin
                if (!a[0]) a_nxt = a >> 1;
                else       state_nxt = NORM_B;
            end
            NORM_B: begin
                if (!b[0]) b_nxt = b >> 1;
                else       state_nxt = ORDER;
            end
            ORDER: begin
                if (a > b) begin
                    a_nxt = b;
                    b_nxt = a;
                end
                state_nxt = SUB;
            end
            SUB: begin
                if (diff == '0) begin
                    result_nxt = a << k;
                    state_nxt  = DONE;
                end else begin
                    b_nxt     = diff;
                    state_nxt = NORM_B;
                end
            end
            DONE: if (ack_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // The last busy cycle is included in the reported count.
        if (busy && state_nxt == DONE) begin
            cycles_nxt  = cnt_inc;
            coprime_nxt = (result_nxt == WIDTH'(1));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            a       <= '0;
            b       <= '0;
            k       <= '0;
            cnt     <= '0;
            result  <= '0;
            coprime <= 1'b0;
            cycles  <= '0;
        end else begin
            state   <= state_nxt;
            a       <= a_nxt;
            b       <= b_nxt;
            k       <= k_nxt;
            cnt     <= cnt_nxt;
            result  <= result_nxt;
            coprime <= coprime_nxt;
            cycles  <= cycles_nxt;
        end
    end

    assign busy_o    = busy;
    assign valid_o   = (state == DONE);
    assign result_o  = result;
    assign coprime_o = coprime;
    assign cycles_o  = cycles;
endmodule

// File: tb/tb_gcd_stream.sv
// Scoreboard bench for gcd_stream: a 32-bit instance for directed cases and an
// 8-bit instance with a 4-bit counter for random and saturation checks.
module tb_gcd_stream;
    logic        clk = 1'b0;
    logic        rst;
    logic        start32, ack32, busy32, valid32, cop32;
    logic [31:0] a32, b32, res32;
    logic [15:0] cyc32;
    logic        start8, ack8, busy8, valid8, cop8;
    logic [7:0]  a8, b8, res8;
    logic [3:0]  cyc8;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] q32[$];
    logic [7:0]  q8[$];

    always #5 clk = ~clk;

    gcd_stream #(.WIDTH(32), .CNT_W(16)) dut32 (
        .clk_i(clk), .rst_i(rst), .start_i(start32), .a_i(a32), .b_i(b32),
        .ack_i(ack32), .busy_o(busy32), .valid_o(valid32), .result_o(res32),
        .coprime_o(cop32), .cycles_o(cyc32));

    gcd_stream #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .a_i(a8), .b_i(b8),
        .ack_i(ack8), .busy_o(busy8), .valid_o(valid8), .result_o(res8),
        .coprime_o(cop8), .cycles_o(cyc8));

    // Euclid reference, independent of the Stein datapath.
    function automatic logic [31:0] gref(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Called at a negedge with the DUT idle. poke pulses start with other
    // operands while busy and holds it through the back-pressure window.
    task automatic run32(input logic [31:0] x, input logic [31:0] y,
                         input int hold, input bit poke);
        int nb = 0;
        bit got = 0;
        logic [31:0] exp;
        start32 = 1; a32 = x; b32 = y;
        q32.push_back(gref(x, y));
        for (int i = 0; i < 20000 && !got; i++) begin
            @(negedge clk);
            start32 = poke && (i == 0);
            if (poke) begin a32 = 32'd17; b32 = 32'd5; end
            if (busy32) nb++;
            if (valid32) got = 1;
        end
        exp = q32.pop_front();
        n_checks++;
        if (!got) $display("FAIL timeout32 gcd(%0d,%0d) no valid_o", x, y);
        else n_pass++;
        for (int i = 0; i < hold; i++) begin
            start32 = poke;
            @(negedge clk);
            n_checks++;
            if (valid32 !== 1'b1 || res32 !== exp)
                $display("FAIL hold32 cyc %0d valid=%b res=%0h exp valid=1 res=%0h", i, valid32, res32, exp);
            else n_pass++;
        end
        start32 = 0;
        n_checks++;
        if (res32 !== exp) $display("FAIL result32 gcd(%0d,%0d) got %0h exp %0h", x, y, res32, exp);
        else n_pass++;
        n_checks++;
        if (cop32 !== (exp == 32'd1)) $display("FAIL coprime32 gcd(%0d,%0d) got %b exp %b", x, y, cop32, exp == 32'd1);
        else n_pass++;
        n_checks++;
        if (cyc32 !== 16'(nb)) $display("FAIL cycles32 gcd(%0d,%0d) got %0d exp %0d", x, y, cyc32, nb);
        else n_pass++;
        ack32 = 1;
        @(negedge clk);
        ack32 = 0;
        n_checks++;
        if (valid32 !== 1'b0) $display("FAIL vdrop32 gcd(%0d,%0d) valid=%b exp 0", x, y, valid32);
        else n_pass++;
    endtask

    task automatic run8(input logic [7:0] x, input logic [7:0] y);
        int nb = 0;
        bit got = 0;
        logic [7:0] exp;
        logic [3:0] ecyc;
        start8 = 1; a8 = x; b8 = y;
        q8.push_back(8'(gref(32'(x), 32'(y))));
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge clk);
            start8 = 0;
            if (busy8) nb++;
            if (valid8) got = 1;
        end
        exp  = q8.pop_front();
        ecyc = (nb > 15) ? 4'hF : 4'(nb);
        n_checks++;
        if (!got || res8 !== exp || cop8 !== (exp == 8'd1) || cyc8 !== ecyc)
            $display("FAIL rand8 gcd(%0d,%0d) got res=%0d cop=%b cyc=%0d exp res=%0d cop=%b cyc=%0d",
                     x, y, res8, cop8, cyc8, exp, exp == 8'd1, ecyc);
        else n_pass++;
        ack8 = 1;
        @(negedge clk);
        ack8 = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        start32 = 0; ack32 = 0; a32 = 0; b32 = 0;
        start8 = 0; ack8 = 0; a8 = 0; b8 = 0;
        #1;
        n_checks++;
        if ({busy32, valid32, res32, cop32, cyc32} !== '0)
            $display("FAIL reset32 busy=%b valid=%b res=%0h cop=%b cyc=%0d exp all 0", busy32, valid32, res32, cop32, cyc32);
        else n_pass++;
        n_checks++;
        if ({busy8, valid8, res8, cop8, cyc8} !== '0)
            $display("FAIL reset8 busy=%b valid=%b res=%0h cop=%b cyc=%0d exp all 0", busy8, valid8, res8, cop8, cyc8);
        else n_pass++;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run32(32'd48, 32'd18, 0, 0);
        run32(32'd17, 32'd5, 0, 0);
        run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run32(32'h8000_0000, 32'h4000_0000, 0, 0);
        run32(32'd12, 32'd0, 0, 0);
    endtask

    task automatic test_zero();
        start32 = 1; a32 = 0; b32 = 7;
        @(negedge clk);
        start32 = 0;
        n_checks++;
        if (valid32 !== 1'b0 || busy32 !== 1'b1) $display("FAIL zero_lat1 valid=%b busy=%b exp 0/1", valid32, busy32);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (valid32 !== 1'b1 || busy32 !== 1'b0) $display("FAIL zero_lat2 valid=%b busy=%b exp 1/0", valid32, busy32);
        else n_pass++;
        n_checks++;
        if (res32 !== 32'd7 || cyc32 !== 16'd1) $display("FAIL zero_b7 res=%0d cyc=%0d exp 7/1", res32, cyc32);
        else n_pass++;
        ack32 = 1;
        @(negedge clk);
        ack32 = 0;
        run32(32'd0, 32'd0, 0, 0);
    endtask

    task automatic test_backpressure_ignore();
        run32(32'd48, 32'd18, 10, 1);
        run32(32'd0, 32'd9, 3, 1);
    endtask

    task automatic test_back_to_back();
        run32(32'd100, 32'd75, 0, 0);
        run32(32'd81, 32'd27, 0, 0);
        run32(32'd13, 32'd39, 0, 0);
    endtask

    task automatic test_reset_mid();
        start32 = 1; a32 = 32'd1000; b32 = 32'd250;
        @(negedge clk);
        start32 = 0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (busy32 !== 1'b1) $display("FAIL mid_busy busy=%b exp 1", busy32);
        else n_pass++;
        #2 rst = 1;
        #1;
        n_checks++;
        if ({busy32, valid32, res32, cop32, cyc32} !== '0)
            $display("FAIL mid_reset busy=%b valid=%b res=%0h cop=%b cyc=%0d exp all 0", busy32, valid32, res32, cop32, cyc32);
        else n_pass++;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        run32(32'd1000, 32'd250, 0, 0);
    endtask

    task automatic test_random8();
        for (int i = 0; i < 1000; i++)
            run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    endtask

    task automatic test_saturation();
        run8(8'd1, 8'd255);
        n_checks++;
        if (cyc8 !== 4'hF) $display("FAIL sat8 cycles=%0d exp 15", cyc8);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_backpressure_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random8();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
